// File: rtl/vga_pkg.sv
// Shared VGA timing constants and colour types for the pixel-colour stages.
package vga_pkg;

  localparam int unsigned X0       = 50;
  localparam int unsigned Y0       = 33;
  localparam int unsigned ACTIVE_W = 640;
  localparam int unsigned ACTIVE_H = 480;
  localparam int unsigned COLOR_W  = 3;
  localparam int unsigned COORD_W  = 12;

  // One pixel colour, packed as {R,G,B}
  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb_t;

endpackage

// File: rtl/vga_bounce_axis.sv
// One axis of the bouncing box: position in [0, MAX] plus direction,
// stepped once per frame tick and reflected at either end.
module vga_bounce_axis
  import vga_pkg::*;
#(
  parameter int unsigned MAX  = 608,
  parameter int unsigned STEP = 2
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic               tick,
  input  logic               pause,
  output logic [COORD_W-1:0] pos,
  output logic               dir       // 0 = increasing, 1 = decreasing
);

  localparam int unsigned SUM_W = COORD_W + 1;

  logic [COORD_W-1:0] pos_nxt;
  logic               dir_nxt;
  logic [SUM_W-1:0]   pos_inc;

  // Extra bit keeps pos+STEP from wrapping before the compare against MAX
  assign pos_inc = {1'b0, pos} + SUM_W'(STEP);

  // Next position/direction; clamp and reverse at the edges
  always_comb begin
    pos_nxt = pos;
    dir_nxt = dir;
    if (tick && !pause) begin
      if (!dir) begin
        if (pos_inc >= SUM_W'(MAX)) begin
          pos_nxt = COORD_W'(MAX);
          dir_nxt = 1'b1;
        end else begin
          pos_nxt = pos_inc[COORD_W-1:0];
        end
      end else begin
        if (pos <= COORD_W'(STEP)) begin
          pos_nxt = '0;
          dir_nxt = 1'b0;
        end else begin
          pos_nxt = pos - COORD_W'(STEP);
        end
      end
    end
  end

  // Position/direction state
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      pos <= '0;
      dir <= 1'b0;
    end else begin
      pos <= pos_nxt;
      dir <= dir_nxt;
    end
  end

endmodule

// File: rtl/vga_bounce_box.sv
// Pixel-colour stage: draws a bouncing solid box over a background colour,
// with syncs and valid re-aligned to the 2-cycle colour pipeline.
module vga_bounce_box
  import vga_pkg::*;
#(
  parameter int unsigned X0       = vga_pkg::X0,
  parameter int unsigned Y0       = vga_pkg::Y0,
  parameter int unsigned ACTIVE_W = vga_pkg::ACTIVE_W,
  parameter int unsigned ACTIVE_H = vga_pkg::ACTIVE_H,
  parameter int unsigned BOX_W    = 32,
  parameter int unsigned BOX_H    = 32,
  parameter int unsigned STEP_X   = 2,
  parameter int unsigned STEP_Y   = 1,
  parameter rgb_t        BOX_RGB  = rgb_t'(9'b111_111_000),
  parameter rgb_t        BG_RGB   = rgb_t'(9'b000_000_001)
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic               i_HSync,
  input  logic               i_VSync,
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  logic               i_valid,
  input  logic               i_Pause,
  output logic [COLOR_W-1:0] o_R,
  output logic [COLOR_W-1:0] o_G,
  output logic [COLOR_W-1:0] o_B,
  output logic               o_HSync,
  output logic               o_VSync,
  output logic               o_valid,
  output logic [COORD_W-1:0] o_BoxX,
  output logic [COORD_W-1:0] o_BoxY,
  output logic [7:0]         o_Frame
);

  localparam int unsigned SUM_W = COORD_W + 1;

  logic               vs_prev;
  logic               frame_tick_c;
  logic               dir_x;
  logic               dir_y;
  logic               unused_dirs;

  logic [COORD_W-1:0] s1_rel_x;
  logic [COORD_W-1:0] s1_rel_y;
  logic               s1_valid;
  logic               s1_hsync;
  logic               s1_vsync;

  logic               inside_c;
  rgb_t               pix_c;

  // Vsync falling edge; vs_prev resets low so a high must be seen first
  always_ff @(posedge i_Clk) begin
    if (i_Reset) vs_prev <= 1'b0;
    else         vs_prev <= i_VSync;
  end

  assign frame_tick_c = vs_prev && !i_VSync;

  // Frame counter, counts every tick whether paused or not
  always_ff @(posedge i_Clk) begin
    if (i_Reset)           o_Frame <= '0;
    else if (frame_tick_c) o_Frame <= o_Frame + 8'd1;
  end

  vga_bounce_axis #(
    .MAX  (ACTIVE_W - BOX_W),
    .STEP (STEP_X)
  ) u_axis_x (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .tick    (frame_tick_c),
    .pause   (i_Pause),
    .pos     (o_BoxX),
    .dir     (dir_x)
  );

  vga_bounce_axis #(
    .MAX  (ACTIVE_H - BOX_H),
    .STEP (STEP_Y)
  ) u_axis_y (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .tick    (frame_tick_c),
    .pause   (i_Pause),
    .pos     (o_BoxY),
    .dir     (dir_y)
  );

  // Direction bits are internal to the axes; only positions leave the block
  assign unused_dirs = dir_x ^ dir_y;

  // Stage 1: active-relative coordinates and control alignment
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      s1_rel_x <= '0;
      s1_rel_y <= '0;
      s1_valid <= 1'b0;
      s1_hsync <= 1'b1;
      s1_vsync <= 1'b1;
    end else begin
      s1_rel_x <= i_x - COORD_W'(X0);
      s1_rel_y <= i_y - COORD_W'(Y0);
      s1_valid <= i_valid;
      s1_hsync <= i_HSync;
      s1_vsync <= i_VSync;
    end
  end

  // Box hit test against the current (pre-update on a tick) position
  always_comb begin
    inside_c = (s1_rel_x >= o_BoxX) &&
               ({1'b0, s1_rel_x} < ({1'b0, o_BoxX} + SUM_W'(BOX_W))) &&
               (s1_rel_y >= o_BoxY) &&
               ({1'b0, s1_rel_y} < ({1'b0, o_BoxY} + SUM_W'(BOX_H)));
    pix_c = '0;
    if (s1_valid) pix_c = inside_c ? BOX_RGB : BG_RGB;
  end

  // Stage 2: registered colour and re-aligned syncs
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      o_R     <= '0;
      o_G     <= '0;
      o_B     <= '0;
      o_valid <= 1'b0;
      o_HSync <= 1'b1;
      o_VSync <= 1'b1;
    end else begin
      o_R     <= pix_c.r;
      o_G     <= pix_c.g;
      o_B     <= pix_c.b;
      o_valid <= s1_valid;
      o_HSync <= s1_hsync;
      o_VSync <= s1_vsync;
    end
  end

endmodule

// File: tb/tb_vga_bounce_box.sv
// Directed bench for vga_bounce_box: pixel vectors, motion, bounce, pause, reset.
module tb_vga_bounce_box;

  logic        i_Clk = 1'b0;
  logic        i_Reset;
  logic        i_HSync;
  logic        i_VSync;
  logic [11:0] i_x;
  logic [11:0] i_y;
  logic        i_valid;
  logic        i_Pause;
  logic [2:0]  o_R;
  logic [2:0]  o_G;
  logic [2:0]  o_B;
  logic        o_HSync;
  logic        o_VSync;
  logic        o_valid;
  logic [11:0] o_BoxX;
  logic [11:0] o_BoxY;
  logic [7:0]  o_Frame;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [11:0] x;
    logic [11:0] y;
    logic        valid;
    logic [8:0]  rgb;
  } vec_t;

  vec_t vecs[7];

  always #5 i_Clk = ~i_Clk;

  vga_bounce_box dut (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_HSync (i_HSync),
    .i_VSync (i_VSync),
    .i_x     (i_x),
    .i_y     (i_y),
    .i_valid (i_valid),
    .i_Pause (i_Pause),
    .o_R     (o_R),
    .o_G     (o_G),
    .o_B     (o_B),
    .o_HSync (o_HSync),
    .o_VSync (o_VSync),
    .o_valid (o_valid),
    .o_BoxX  (o_BoxX),
    .o_BoxY  (o_BoxY),
    .o_Frame (o_Frame)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_Clk);
      #1;
    end
  endtask

  // One vsync falling edge followed by a return high
  task automatic tick();
    i_VSync = 1'b0;
    step(1);
    i_VSync = 1'b1;
    step(1);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic pix(input string nm, input logic [11:0] x, input logic [11:0] y,
                     input logic v, input logic [8:0] rgb);
    i_x     = x;
    i_y     = y;
    i_valid = v;
    step(2);
    chk(nm, 32'({o_R, o_G, o_B}), 32'(rgb));
    chk({nm, "_valid"}, 32'(o_valid), 32'(v));
  endtask

  initial begin
    vecs[0] = '{"origin_box",   12'd50, 12'd33, 1'b1, 9'b111_111_000};
    vecs[1] = '{"right_of_box", 12'd82, 12'd33, 1'b1, 9'b000_000_001};
    vecs[2] = '{"box_corner",   12'd81, 12'd64, 1'b1, 9'b111_111_000};
    vecs[3] = '{"below_box",    12'd81, 12'd65, 1'b1, 9'b000_000_001};
    vecs[4] = '{"not_valid",    12'd60, 12'd40, 1'b0, 9'b000_000_000};
    vecs[5] = '{"left_wrap",    12'd49, 12'd33, 1'b1, 9'b000_000_001};
    vecs[6] = '{"above_box",    12'd50, 12'd32, 1'b1, 9'b000_000_001};

    // Reset with arbitrary inputs
    i_Reset = 1'b1;
    i_HSync = 1'b0;
    i_VSync = 1'b0;
    i_x     = 12'd50;
    i_y     = 12'd33;
    i_valid = 1'b1;
    i_Pause = 1'b0;
    step(2);
    chk("rst_rgb",   32'({o_R, o_G, o_B}), 32'd0);
    chk("rst_hsync", 32'(o_HSync), 32'd1);
    chk("rst_vsync", 32'(o_VSync), 32'd1);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_boxx",  32'(o_BoxX), 32'd0);
    chk("rst_boxy",  32'(o_BoxY), 32'd0);
    chk("rst_frame", 32'(o_Frame), 32'd0);

    i_Reset = 1'b0;
    i_HSync = 1'b1;
    i_VSync = 1'b1;
    step(1);

    // Pixel vectors with the box at (0,0)
    for (int i = 0; i < 7; i++)
      pix(vecs[i].name, vecs[i].x, vecs[i].y, vecs[i].valid, vecs[i].rgb);

    // Hsync fall shows up exactly two cycles later
    i_HSync = 1'b0;
    step(1);
    chk("hsync_t1", 32'(o_HSync), 32'd1);
    step(1);
    chk("hsync_t2", 32'(o_HSync), 32'd0);
    i_HSync = 1'b1;
    step(2);
    chk("hsync_back", 32'(o_HSync), 32'd1);

    // Three frames of motion
    ticks(3);
    chk("mv_boxx",  32'(o_BoxX), 32'd6);
    chk("mv_boxy",  32'(o_BoxY), 32'd3);
    chk("mv_frame", 32'(o_Frame), 32'd3);
    pix("mv_left_edge_bg", 12'd55, 12'd36, 1'b1, 9'b000_000_001);
    pix("mv_left_edge_box", 12'd56, 12'd36, 1'b1, 9'b111_111_000);
    i_valid = 1'b0;

    // X bounce at MAX=608
    ticks(301);
    chk("bx_304", 32'(o_BoxX), 32'd608);
    tick();
    chk("bx_305", 32'(o_BoxX), 32'd606);
    chk("frame_305", 32'(o_Frame), 32'd49);

    // Y bounce at MAX=448
    ticks(143);
    chk("by_448", 32'(o_BoxY), 32'd448);
    tick();
    chk("by_449", 32'(o_BoxY), 32'd447);
    chk("bx_449", 32'(o_BoxX), 32'd318);
    chk("frame_449", 32'(o_Frame), 32'd193);

    // Pause freezes motion but not the frame counter
    i_Pause = 1'b1;
    ticks(5);
    chk("pause_boxx",  32'(o_BoxX), 32'd318);
    chk("pause_boxy",  32'(o_BoxY), 32'd447);
    chk("pause_frame", 32'(o_Frame), 32'd198);
    i_Pause = 1'b0;
    tick();
    chk("resume_boxx",  32'(o_BoxX), 32'd316);
    chk("resume_boxy",  32'(o_BoxY), 32'd446);
    chk("resume_frame", 32'(o_Frame), 32'd199);

    // Mid-frame reset with vsync held low through release
    i_valid = 1'b1;
    i_x     = 12'd60;
    i_y     = 12'd40;
    i_VSync = 1'b0;
    i_Reset = 1'b1;
    step(2);
    chk("mrst_valid", 32'(o_valid), 32'd0);
    chk("mrst_rgb",   32'({o_R, o_G, o_B}), 32'd0);
    chk("mrst_boxx",  32'(o_BoxX), 32'd0);
    i_Reset = 1'b0;
    step(3);
    chk("mrst_no_tick_frame", 32'(o_Frame), 32'd0);
    chk("mrst_no_tick_boxx",  32'(o_BoxX), 32'd0);
    i_VSync = 1'b1;
    step(1);
    i_VSync = 1'b0;
    step(1);
    chk("mrst_tick_frame", 32'(o_Frame), 32'd1);
    chk("mrst_tick_boxx",  32'(o_BoxX), 32'd2);
    chk("mrst_tick_boxy",  32'(o_BoxY), 32'd1);
    step(2);
    chk("mrst_single_tick", 32'(o_Frame), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
